// File: rtl/hwpe_stream_package.sv
// Shared stream types for the HWPE source/sink datapath.
//   ctrl_addressgen_t  : address-generator job descriptor
//   flags_addressgen_t : address-generator progress flags
//   state_sourcesink_t : source/sink controller FSM state
//   HWPE_STREAM_ADDR_WORD_BYTES : default byte step between words
package hwpe_stream_package;

  localparam int unsigned HWPE_STREAM_ADDR_WORD_BYTES = 4;

  typedef enum logic [1:0] {
    STREAM_IDLE,
    STREAM_WORKING,
    STREAM_DONE
  } state_sourcesink_t;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] trans_size;
    logic [15:0] line_stride;
    logic [15:0] line_length;
    logic [15:0] feat_stride;
    logic [15:0] feat_length;
    logic [15:0] feat_roll;
    logic        loop_outer;
    logic        realign_type;
    logic [7:0]  line_length_remainder;
  } ctrl_addressgen_t;

  typedef struct packed {
    logic       enable;
    logic       last;
    logic       first;
    logic [3:0] strb;
  } flags_realign_t;

  typedef struct packed {
    flags_realign_t realign_flags;
    logic           word_update;
    logic           line_update;
    logic           feat_update;
    logic           in_progress;
  } flags_addressgen_t;

  // A zero loop length behaves as a single-iteration loop.
  function automatic logic [15:0] len_or_one(input logic [15:0] len);
    return (len == '0) ? 16'd1 : len;
  endfunction

endpackage

// File: rtl/hwpe_stream_wrap_counter.sv
// Count/offset pair for one level of the address loop nest.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clear_i       : synchronous clear of count and offset
//   step_i        : advance one iteration
//   wrap_en_i     : allow wrap when the count reaches limit_i
//   limit_i       : iterations per wrap
//   stride_i      : offset increment per iteration
//   off_nxt_o     : offset value after this cycle's update
//   tc_o          : terminal count, the step that wraps this level
module hwpe_stream_wrap_counter #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 step_i,
  input  logic                 wrap_en_i,
  input  logic [CNT_WIDTH-1:0] limit_i,
  input  logic [31:0]          stride_i,
  output logic [31:0]          off_nxt_o,
  output logic                 tc_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]          off_q, off_d;
  logic                 wrap;

  assign cnt_inc   = cnt_q + CNT_WIDTH'(1);
  assign wrap      = wrap_en_i && (cnt_inc == limit_i);
  assign tc_o      = step_i && wrap;
  assign off_nxt_o = off_d;

  always_comb begin
    cnt_d = cnt_q;
    off_d = off_q;
    if (step_i) begin
      if (wrap) begin
        cnt_d = '0;
        off_d = '0;
      end else begin
        cnt_d = cnt_inc;
        off_d = off_q + stride_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      cnt_q <= '0;
      off_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      off_q <= off_d;
    end
  end

endmodule

// File: rtl/hwpe_stream_addr_walker.sv
// Word/line/feature address generator feeding a stream source/sink.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   clear_i         : synchronous soft clear (same as reset)
//   start_i, ctrl_i : job start and descriptor, sampled in STREAM_IDLE
//   addr_o          : registered byte address
//   addr_valid_o    : addr_o valid; addr_ready_i completes the handshake
//   done_o          : one-cycle end-of-job pulse
//   state_o         : FSM state
//   flags_o         : progress flags
module hwpe_stream_addr_walker
  import hwpe_stream_package::*;
#(
  parameter int unsigned WORD_BYTES = HWPE_STREAM_ADDR_WORD_BYTES,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  ctrl_addressgen_t  ctrl_i,
  output logic [31:0]       addr_o,
  output logic              addr_valid_o,
  input  logic              addr_ready_i,
  output logic              done_o,
  output state_sourcesink_t state_o,
  output flags_addressgen_t flags_o
);

  state_sourcesink_t    state_q, state_d;
  logic [31:0]          base_q, base_d;
  logic [31:0]          trans_size_q, trans_size_d;
  logic [31:0]          trans_cnt_q, trans_cnt_d, trans_cnt_inc;
  logic [31:0]          line_stride_q, line_stride_d;
  logic [31:0]          feat_stride_q, feat_stride_d;
  logic [CNT_WIDTH-1:0] line_len_q, line_len_d;
  logic [CNT_WIDTH-1:0] feat_len_q, feat_len_d;
  logic [CNT_WIDTH-1:0] feat_roll_q, feat_roll_d;
  logic                 loop_outer_q, loop_outer_d;
  logic [31:0]          addr_q, addr_d;

  logic        hs, last, cnt_clr, feat_wrap_en;
  logic        word_tc, line_tc, feat_tc;
  logic [31:0] word_nxt, line_nxt, feat_nxt;
  logic        ctrl_unused;
  logic        feat_tc_unused;

  assign ctrl_unused    = ^{ctrl_i.realign_type, ctrl_i.line_length_remainder};
  assign feat_tc_unused = feat_tc;

  assign hs            = addr_valid_o && addr_ready_i;
  assign trans_cnt_inc = trans_cnt_q + 32'd1;
  assign last          = hs && (trans_cnt_inc == trans_size_q);
  // Counters are held cleared outside WORKING so every job starts at offset 0.
  assign cnt_clr       = clear_i || (state_q != STREAM_WORKING);
  assign feat_wrap_en  = loop_outer_q && (feat_roll_q != '0);

  hwpe_stream_wrap_counter #(.CNT_WIDTH(CNT_WIDTH)) i_word_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (cnt_clr),
    .step_i    (hs),
    .wrap_en_i (1'b1),
    .limit_i   (line_len_q),
    .stride_i  (32'(WORD_BYTES)),
    .off_nxt_o (word_nxt),
    .tc_o      (word_tc)
  );

  hwpe_stream_wrap_counter #(.CNT_WIDTH(CNT_WIDTH)) i_line_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (cnt_clr),
    .step_i    (word_tc),
    .wrap_en_i (1'b1),
    .limit_i   (feat_len_q),
    .stride_i  (line_stride_q),
    .off_nxt_o (line_nxt),
    .tc_o      (line_tc)
  );

  hwpe_stream_wrap_counter #(.CNT_WIDTH(CNT_WIDTH)) i_feat_cnt (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (cnt_clr),
    .step_i    (line_tc),
    .wrap_en_i (feat_wrap_en),
    .limit_i   (feat_roll_q),
    .stride_i  (feat_stride_q),
    .off_nxt_o (feat_nxt),
    .tc_o      (feat_tc)
  );

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    trans_size_d  = trans_size_q;
    trans_cnt_d   = trans_cnt_q;
    line_stride_d = line_stride_q;
    feat_stride_d = feat_stride_q;
    line_len_d    = line_len_q;
    feat_len_d    = feat_len_q;
    feat_roll_d   = feat_roll_q;
    loop_outer_d  = loop_outer_q;
    addr_d        = addr_q;
    case (state_q)
      STREAM_IDLE: begin
        if (start_i) begin
          base_d        = ctrl_i.base_addr;
          trans_size_d  = ctrl_i.trans_size;
          trans_cnt_d   = '0;
          line_stride_d = 32'(ctrl_i.line_stride);
          feat_stride_d = 32'(ctrl_i.feat_stride);
          line_len_d    = CNT_WIDTH'(len_or_one(ctrl_i.line_length));
          feat_len_d    = CNT_WIDTH'(len_or_one(ctrl_i.feat_length));
          feat_roll_d   = CNT_WIDTH'(ctrl_i.feat_roll);
          loop_outer_d  = ctrl_i.loop_outer;
          addr_d        = ctrl_i.base_addr;
          state_d       = (ctrl_i.trans_size == '0) ? STREAM_DONE : STREAM_WORKING;
        end
      end
      STREAM_WORKING: begin
        if (hs) begin
          trans_cnt_d = trans_cnt_inc;
          // Register the address the counters will point at after this edge.
          addr_d      = base_q + feat_nxt + line_nxt + word_nxt;
          if (last) state_d = STREAM_DONE;
        end
      end
      STREAM_DONE: state_d = STREAM_IDLE;
      default:     state_d = STREAM_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q       <= STREAM_IDLE;
      base_q        <= '0;
      trans_size_q  <= '0;
      trans_cnt_q   <= '0;
      line_stride_q <= '0;
      feat_stride_q <= '0;
      line_len_q    <= '0;
      feat_len_q    <= '0;
      feat_roll_q   <= '0;
      loop_outer_q  <= 1'b0;
      addr_q        <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      trans_size_q  <= trans_size_d;
      trans_cnt_q   <= trans_cnt_d;
      line_stride_q <= line_stride_d;
      feat_stride_q <= feat_stride_d;
      line_len_q    <= line_len_d;
      feat_len_q    <= feat_len_d;
      feat_roll_q   <= feat_roll_d;
      loop_outer_q  <= loop_outer_d;
      addr_q        <= addr_d;
    end
  end

  assign addr_o       = addr_q;
  assign addr_valid_o = (state_q == STREAM_WORKING);
  assign done_o       = (state_q == STREAM_DONE);
  assign state_o      = state_q;

  always_comb begin
    flags_o               = '0;
    flags_o.word_update   = hs;
    flags_o.line_update   = word_tc;
    flags_o.feat_update   = line_tc;
    flags_o.in_progress   = (state_q == STREAM_WORKING);
  end

endmodule

// File: tb/tb_hwpe_stream_addr_walker.sv
module tb_hwpe_stream_addr_walker;
  import hwpe_stream_package::*;

  typedef struct {
    logic [31:0] addr;
    logic        line_upd;
    logic        feat_upd;
  } exp_t;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              clear_i;
  logic              start_i;
  ctrl_addressgen_t  ctrl_i;
  logic [31:0]       addr_o;
  logic              addr_valid_o;
  logic              addr_ready_i;
  logic              done_o;
  state_sourcesink_t state_o;
  flags_addressgen_t flags_o;

  int   errors = 0;
  int   checks = 0;
  int   hs_count = 0;
  int   done_count = 0;
  exp_t sb[$];

  hwpe_stream_addr_walker #(.WORD_BYTES(4), .CNT_WIDTH(16)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .ctrl_i       (ctrl_i),
    .addr_o       (addr_o),
    .addr_valid_o (addr_valid_o),
    .addr_ready_i (addr_ready_i),
    .done_o       (done_o),
    .state_o      (state_o),
    .flags_o      (flags_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected item per handshake, and checks stall stability.
  logic        stall_prev = 1'b0;
  logic        clr_prev   = 1'b0;
  logic [31:0] addr_prev  = '0;
  always @(negedge clk_i) begin
    if (stall_prev && !clr_prev && rst_ni) begin
      chk("stall_valid", {31'b0, addr_valid_o}, 32'd1);
      chk("stall_addr", addr_o, addr_prev);
    end
    if (addr_valid_o && addr_ready_i) begin
      hs_count++;
      if (sb.size() == 0) begin
        chk("unexpected_handshake", addr_o, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("addr", addr_o, e.addr);
        chk("word_update", {31'b0, flags_o.word_update}, 32'd1);
        chk("line_update", {31'b0, flags_o.line_update}, {31'b0, e.line_upd});
        chk("feat_update", {31'b0, flags_o.feat_update}, {31'b0, e.feat_upd});
      end
    end
    if (done_o) done_count++;
    stall_prev = addr_valid_o && !addr_ready_i;
    clr_prev   = clear_i;
    addr_prev  = addr_o;
  end

  function automatic ctrl_addressgen_t make_ctrl(
    input logic [31:0] base, input logic [31:0] trans,
    input logic [15:0] ll, input logic [15:0] ls,
    input logic [15:0] fl, input logic [15:0] fs,
    input logic [15:0] roll, input logic outer);
    ctrl_addressgen_t c;
    c = '0;
    c.base_addr   = base;
    c.trans_size  = trans;
    c.line_length = ll;
    c.line_stride = ls;
    c.feat_length = fl;
    c.feat_stride = fs;
    c.feat_roll   = roll;
    c.loop_outer  = outer;
    return c;
  endfunction

  task automatic push(input logic [31:0] a, input logic l, input logic f);
    exp_t e;
    e.addr = a; e.line_upd = l; e.feat_upd = f;
    sb.push_back(e);
  endtask

  task automatic push_basic();
    push(32'h1000, 0, 0); push(32'h1004, 0, 0); push(32'h1008, 1, 0);
    push(32'h1100, 0, 0); push(32'h1104, 0, 0); push(32'h1108, 1, 1);
  endtask

  // Returns after start_i has been sampled (edge N + 1 time unit).
  task automatic start_job(input ctrl_addressgen_t c);
    @(posedge clk_i); #1;
    ctrl_i  = c;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // Counts negedges until done_o; then checks the return to IDLE.
  task automatic wait_done(input string name, input int exp_cyc);
    int cyc;
    logic seen;
    cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      cyc++;
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      if (exp_cyc > 0) chk({name, "_latency"}, cyc, exp_cyc);
      chk({name, "_valid_at_done"}, {31'b0, addr_valid_o}, 32'd0);
      @(negedge clk_i);
      chk({name, "_done_pulse"}, {31'b0, done_o}, 32'd0);
      chk({name, "_idle"}, {30'b0, state_o}, {30'b0, STREAM_IDLE});
    end
    chk({name, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  initial begin
    int hs0, d0;
    logic any_valid;
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; addr_ready_i = 1'b1;
    ctrl_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_addr", addr_o, 32'h0);
    chk("rst_valid", {31'b0, addr_valid_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_state", {30'b0, state_o}, {30'b0, STREAM_IDLE});
    chk("rst_flags", 32'(flags_o), 32'd0);

    // Basic nest, ready high.
    push_basic();
    hs0 = hs_count;
    start_job(make_ctrl(32'h1000, 6, 3, 16'h100, 2, 16'h1000, 0, 0));
    wait_done("basic", 7);
    chk("basic_hs", hs_count - hs0, 32'd6);

    // Backpressure: ready low for 5 cycles while 0x1004 is presented.
    push_basic();
    hs0 = hs_count;
    start_job(make_ctrl(32'h1000, 6, 3, 16'h100, 2, 16'h1000, 0, 0));
    @(posedge clk_i); #1 addr_ready_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1 addr_ready_i = 1'b1;
    wait_done("bp", 6);
    chk("bp_hs", hs_count - hs0, 32'd6);

    // Outer wrap.
    push(32'h0, 1, 1); push(32'h40, 1, 1); push(32'h0, 1, 1); push(32'h40, 1, 1);
    start_job(make_ctrl(32'h0, 4, 1, 16'h0, 1, 16'h40, 2, 1));
    wait_done("wrap", 5);

    // Empty job: no valid, done one cycle after start.
    any_valid = 1'b0;
    start_job(make_ctrl(32'h2000, 0, 3, 16'h100, 2, 16'h1000, 0, 0));
    @(negedge clk_i);
    any_valid |= addr_valid_o;
    chk("empty_done", {31'b0, done_o}, 32'd1);
    @(negedge clk_i);
    any_valid |= addr_valid_o;
    chk("empty_done_pulse", {31'b0, done_o}, 32'd0);
    chk("empty_idle", {30'b0, state_o}, {30'b0, STREAM_IDLE});
    chk("empty_no_valid", {31'b0, any_valid}, 32'd0);

    // Clear after the 2nd handshake; the pending address is dropped.
    push(32'h1000, 0, 0); push(32'h1004, 0, 0);
    d0 = done_count;
    start_job(make_ctrl(32'h1000, 6, 3, 16'h100, 2, 16'h1000, 0, 0));
    @(posedge clk_i);
    @(posedge clk_i); #1;
    clear_i = 1'b1; addr_ready_i = 1'b0;
    @(posedge clk_i); #1;
    clear_i = 1'b0; addr_ready_i = 1'b1;
    @(negedge clk_i);
    chk("clr_valid", {31'b0, addr_valid_o}, 32'd0);
    chk("clr_idle", {30'b0, state_o}, {30'b0, STREAM_IDLE});
    repeat (3) @(negedge clk_i);
    chk("clr_no_done", done_count - d0, 32'd0);
    chk("clr_sb_empty", sb.size(), 32'd0);
    push_basic();
    start_job(make_ctrl(32'h1000, 6, 3, 16'h100, 2, 16'h1000, 0, 0));
    wait_done("replay", 7);

    // Start while busy is ignored, even with a different descriptor.
    push_basic();
    hs0 = hs_count;
    start_job(make_ctrl(32'h1000, 6, 3, 16'h100, 2, 16'h1000, 0, 0));
    @(posedge clk_i); #1;
    ctrl_i  = make_ctrl(32'h8000, 2, 1, 16'h10, 1, 16'h20, 0, 0);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done("busy", 5);
    chk("busy_hs", hs_count - hs0, 32'd6);

    repeat (3) @(negedge clk_i);
    chk("final_idle", {30'b0, state_o}, {30'b0, STREAM_IDLE});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
